// File: rtl/puf_seq_pkg.sv
// Shared types and defaults for the serial PUF evaluation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package puf_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        RUN,
        CAPTURE,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_RESP_BITS      = 8;
    localparam int DEF_SETTLE_CYCLES  = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1048576;
    localparam int DEF_SYNC_STAGES    = 2;

    localparam logic [31:0] RO_ALL_ON = 32'hFFFF_FFFF;

    // Counters and arbiter stay cleared unless a race is running or being sampled.
    function automatic logic holds_reset(input state_t s);
        return !(s == RUN || s == CAPTURE);
    endfunction

endpackage

// File: rtl/puf_sequencer_bit_sync.sv
// Multi-flop synchronizer bringing one RO-domain signal into the clock domain.
// Latency: STAGES cycles.
// Backpressure: none.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/puf_sequencer.sv
// Runs one serial PUF evaluation per accepted challenge, one race per response bit.
// Latency: 2 + per bit (SETTLE + race + SYNC_STAGES + 2) - 1 cycles to resp_valid.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready.
module puf_sequencer
    import puf_seq_pkg::*;
#(
    parameter int RESP_BITS      = DEF_RESP_BITS,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           challenge,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [RESP_BITS-1:0] response,
    output logic                 resp_error,
    output logic                 busy,
    output logic [7:0]           scr_challenge,
    output logic                 scr_reset,
    output logic                 scr_increment,
    output logic [31:0]          ro_enable,
    output logic                 cnt_reset,
    output logic                 arb_reset,
    input  logic                 arb_done,
    input  logic                 arb_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int IW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    logic done_sync;
    logic out_sync;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_done (
        .clock (clock),
        .reset (reset),
        .d     (arb_done),
        .q     (done_sync)
    );

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync_out (
        .clock (clock),
        .reset (reset),
        .d     (arb_out),
        .q     (out_sync)
    );

    state_t                state_q, state_d;
    logic [IW-1:0]         bit_idx_q, bit_idx_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [RESP_BITS-1:0]  response_q, response_d;
    logic                  resp_error_q, resp_error_d;
    logic [7:0]            scr_challenge_q, scr_challenge_d;
    logic                  scr_reset_q, scr_reset_d;
    logic                  scr_increment_q, scr_increment_d;
    logic [31:0]           ro_enable_q, ro_enable_d;
    logic                  cnt_reset_q, cnt_reset_d;
    logic                  arb_reset_q, arb_reset_d;
    logic                  resp_valid_q, resp_valid_d;

    always_comb begin
        state_d         = state_q;
        bit_idx_d       = bit_idx_q;
        settle_d        = settle_q;
        tmo_d           = tmo_q;
        response_d      = response_q;
        resp_error_d    = resp_error_q;
        scr_challenge_d = scr_challenge_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    scr_challenge_d = challenge;
                    response_d      = '0;
                    resp_error_d    = 1'b0;
                    bit_idx_d       = '0;
                    state_d         = LOAD;
                end
            end
            LOAD: begin
                settle_d = '0;
                state_d  = CLEAR;
            end
            CLEAR: begin
                if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
                    tmo_d   = '0;
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            RUN: begin
                if (done_sync) begin
                    state_d = CAPTURE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    resp_error_d = 1'b1;
                    state_d      = DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CAPTURE: begin
                // arb_out has had one extra cycle past done to settle.
                response_d[bit_idx_q] = out_sync;
                if (bit_idx_q == IW'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = bit_idx_q + IW'(1);
                    state_d   = NEXT;
                end
            end
            NEXT: begin
                settle_d = '0;
                state_d  = CLEAR;
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Datapath controls are decoded from the next state so they line up with it.
        scr_reset_d     = (state_d == LOAD);
        scr_increment_d = (state_d == NEXT);
        ro_enable_d     = (state_d == RUN) ? RO_ALL_ON : 32'h0;
        cnt_reset_d     = holds_reset(state_d);
        arb_reset_d     = holds_reset(state_d);
        resp_valid_d    = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            bit_idx_q       <= '0;
            settle_q        <= '0;
            tmo_q           <= '0;
            response_q      <= '0;
            resp_error_q    <= 1'b0;
            scr_challenge_q <= 8'h00;
            scr_reset_q     <= 1'b0;
            scr_increment_q <= 1'b0;
            ro_enable_q     <= 32'h0;
            cnt_reset_q     <= 1'b1;
            arb_reset_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_idx_q       <= bit_idx_d;
            settle_q        <= settle_d;
            tmo_q           <= tmo_d;
            response_q      <= response_d;
            resp_error_q    <= resp_error_d;
            scr_challenge_q <= scr_challenge_d;
            scr_reset_q     <= scr_reset_d;
            scr_increment_q <= scr_increment_d;
            ro_enable_q     <= ro_enable_d;
            cnt_reset_q     <= cnt_reset_d;
            arb_reset_q     <= arb_reset_d;
            resp_valid_q    <= resp_valid_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign resp_valid    = resp_valid_q;
    assign response      = response_q;
    assign resp_error    = resp_error_q;
    assign scr_challenge = scr_challenge_q;
    assign scr_reset     = scr_reset_q;
    assign scr_increment = scr_increment_q;
    assign ro_enable     = ro_enable_q;
    assign cnt_reset     = cnt_reset_q;
    assign arb_reset     = arb_reset_q;

endmodule

// File: tb/tb_puf_sequencer.sv
// Bench for puf_sequencer: arbiter model driven by the DUT controls, transaction-level
// expectations (response bits, error, pulse counts, latency) and per-cycle invariants.
module tb_puf_sequencer;

    localparam int N    = 8;
    localparam int S    = 4;
    localparam int TMO  = 64;
    localparam int SYN  = 2;
    localparam logic [31:0] ALL_ON = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, resp_valid, resp_ready, resp_error, busy;
    logic [7:0]    challenge, scr_challenge;
    logic [N-1:0]  response;
    logic          scr_reset, scr_increment, cnt_reset, arb_reset;
    logic [31:0]   ro_enable;
    logic          arb_done, arb_out;

    puf_sequencer #(
        .RESP_BITS(N), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYN)
    ) dut (
        .clock(clk), .reset(rst),
        .req_valid(req_valid), .req_ready(req_ready), .challenge(challenge),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .response(response),
        .resp_error(resp_error), .busy(busy), .scr_challenge(scr_challenge),
        .scr_reset(scr_reset), .scr_increment(scr_increment), .ro_enable(ro_enable),
        .cnt_reset(cnt_reset), .arb_reset(arb_reset),
        .arb_done(arb_done), .arb_out(arb_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbiter model: race i completes race_r[i] RO-enabled cycles after the arbiter is released.
    int         race_r [N];
    logic [N-1:0] race_w;
    int         never_from = N;
    int         race_idx = 0;
    int         race_cnt = 0;
    logic       mdl_done = 1'b0, mdl_out = 1'b0, stale = 1'b0;

    assign arb_done = mdl_done | stale;
    assign arb_out  = mdl_out;

    initial begin
        forever begin
            @(negedge clk);
            if (scr_reset) race_idx = 0;
            else if (scr_increment) race_idx++;
            if (arb_reset) begin
                race_cnt = 0; mdl_done = 1'b0; mdl_out = 1'b0;
            end else if (ro_enable == ALL_ON) begin
                race_cnt++;
                if (race_idx < never_from && race_idx < N && race_cnt >= race_r[race_idx]) begin
                    mdl_done = 1'b1;
                    mdl_out  = race_w[race_idx];
                end
            end
        end
    end

    // Expectations for the next request, derived from the race table.
    logic [N-1:0] nxt_resp;
    logic         nxt_err;
    int           nxt_lat, nxt_inc;

    task automatic set_model();
        nxt_resp = '0;
        nxt_lat  = 2;
        for (int i = 0; i < N; i++) begin
            if (i < never_from) begin
                nxt_resp[i] = race_w[i];
                nxt_lat += S + race_r[i] + SYN + 1;
                if (i < N - 1) nxt_lat += 1;
            end else begin
                nxt_lat += S + TMO;
                break;
            end
        end
        nxt_err = (never_from < N);
        nxt_inc = (never_from < N) ? never_from : N - 1;
    endtask

    // Compare process.
    logic [N-1:0] cur_resp = '0;
    logic         cur_err = 1'b0;
    int           cur_lat = 0, cur_inc = 0;
    logic [7:0]   cur_chal = 8'h00;
    logic         in_eval = 1'b0, hs_pending = 1'b0, first_ro = 1'b0;
    logic         prev_rv = 1'b0;
    logic [31:0]  prev_ro = 32'h0;
    int           t_acc = 0, n_rst = 0, n_inc = 0, ro_rise = 0, last_lat = 0, last_inc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", 32'(req_ready), 1);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_resp_valid", 32'(resp_valid), 0);
                chk("rst_response", 32'(response), 0);
                chk("rst_resp_error", 32'(resp_error), 0);
                chk("rst_ro_enable", ro_enable, 0);
                chk("rst_cnt_reset", 32'(cnt_reset), 1);
                chk("rst_arb_reset", 32'(arb_reset), 1);
                chk("rst_scr_pulses", 32'({scr_reset, scr_increment}), 0);
                chk("rst_scr_challenge", 32'(scr_challenge), 0);
                cur_resp = '0; cur_err = 1'b0; in_eval = 1'b0; hs_pending = 1'b0;
                prev_ro = 32'h0; prev_rv = 1'b0;
            end else begin
                chk("busy_vs_ready", 32'(busy), 32'(!req_ready));
                if (hs_pending) begin
                    chk("hs_valid_drop", 32'(resp_valid), 0);
                    chk("hs_ready_back", 32'(req_ready), 1);
                    hs_pending = 1'b0;
                end
                if (!busy) begin
                    chk("idle_ro_enable", ro_enable, 0);
                    chk("idle_resets", 32'({cnt_reset, arb_reset}), 3);
                    chk("idle_resp_valid", 32'(resp_valid), 0);
                    chk("idle_scr_pulses", 32'({scr_reset, scr_increment}), 0);
                    chk("hold_response", 32'(response), 32'(cur_resp));
                    chk("hold_resp_error", 32'(resp_error), 32'(cur_err));
                end else begin
                    chk("scr_challenge", 32'(scr_challenge), 32'(cur_chal));
                end
                chk("ro_all_or_none", 32'(ro_enable == 32'h0 || ro_enable == ALL_ON), 1);
                if (ro_enable == ALL_ON)
                    chk("run_resets_low", 32'({cnt_reset, arb_reset}), 0);
                if (in_eval && cyc == t_acc + 1)
                    chk("scr_reset_at_T1", 32'(scr_reset), 1);
                if (scr_reset) n_rst++;
                if (scr_increment) n_inc++;
                if (ro_enable == ALL_ON && prev_ro != ALL_ON) begin
                    if (in_eval && !first_ro) begin
                        chk("first_run_start", 32'(cyc - t_acc), 32'(2 + S));
                        first_ro = 1'b1;
                    end
                    ro_rise = cyc;
                end
                if (resp_valid) begin
                    chk("resp_response", 32'(response), 32'(cur_resp));
                    chk("resp_error", 32'(resp_error), 32'(cur_err));
                    if (!prev_rv) begin
                        last_lat = cyc - t_acc;
                        last_inc = n_inc;
                        chk("done_latency", 32'(last_lat), 32'(cur_lat));
                        chk("scr_reset_count", 32'(n_rst), 1);
                        chk("scr_inc_count", 32'(n_inc), 32'(cur_inc));
                        if (cur_err) chk("timeout_run_len", 32'(cyc - ro_rise), 32'(TMO));
                    end
                    if (resp_ready) hs_pending = 1'b1;
                end
                if (req_valid && req_ready) begin
                    cur_resp = nxt_resp; cur_err = nxt_err; cur_lat = nxt_lat; cur_inc = nxt_inc;
                    cur_chal = challenge; t_acc = cyc; n_rst = 0; n_inc = 0;
                    first_ro = 1'b0; in_eval = 1'b1;
                end
                prev_ro = ro_enable;
                prev_rv = resp_valid;
            end
            cyc++;
        end
    end

    task automatic start_req(input logic [7:0] ch, input bit stale_en);
        bit acc;
        acc = 1'b0;
        @(posedge clk); #1;
        challenge = ch;
        req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready) begin acc = 1'b1; break; end
        end
        if (!acc) chk("accept_bound", 0, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        challenge = 8'($urandom);
        if (stale_en) begin
            @(posedge clk);
            @(posedge clk); #1;
            stale = 1'b0;
        end
    endtask

    task automatic finish_resp(input int rdy_dly, input bit toggle);
        for (int k = 0; k < 3000; k++) begin
            if (resp_valid) break;
            @(posedge clk); #1;
            if (toggle) begin
                req_valid = 1'($urandom);
                challenge = 8'($urandom);
            end
        end
        req_valid = 1'b0;
        if (!resp_valid) chk("resp_valid_bound", 0, 1);
        repeat (rdy_dly) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_eval(input logic [7:0] ch, input int rdy_dly, input bit toggle, input bit stale_en);
        set_model();
        if (stale_en) stale = 1'b1;
        start_req(ch, stale_en);
        finish_resp(rdy_dly, toggle);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; challenge = 8'h00;
        for (int i = 0; i < N; i++) race_r[i] = 50;
        race_w = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) @(posedge clk);

        // Fixed winners 1,0,1,1,0,0,1,0 with 50-cycle races.
        race_w = 8'b0100_1101; never_from = N;
        run_eval(8'hA5, 0, 1'b0, 1'b0);
        chk("a5_response", 32'(response), 32'h4D);
        chk("a5_error", 32'(resp_error), 0);
        chk("a5_latency", 32'(last_lat), 465);
        chk("a5_increments", 32'(last_inc), 7);

        // Arbiter never finishes: timeout on the first bit.
        never_from = 0;
        run_eval(8'h5A, 0, 1'b0, 1'b0);
        chk("tmo_response", 32'(response), 0);
        chk("tmo_error", 32'(resp_error), 1);
        chk("tmo_latency", 32'(last_lat), 70);

        // Host stalls 20 cycles before taking the result.
        never_from = N;
        run_eval(8'hA5, 20, 1'b0, 1'b0);
        chk("stall_response", 32'(response), 32'h4D);

        // Reset during the RUN of bit 3, then a fresh request.
        for (int i = 0; i < N; i++) race_r[i] = 30;
        race_w = 8'($urandom);
        set_model();
        start_req(8'h77, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            if (race_idx == 3 && ro_enable == ALL_ON) break;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_response", 32'(response), 0);
        race_w = 8'b1010_0110;
        for (int i = 0; i < N; i++) race_r[i] = 3 + i;
        run_eval(8'h3C, 1, 1'b0, 1'b0);
        chk("3c_response", 32'(response), 32'hA6);

        // Stale done entering CLEAR, host toggling req_valid while busy.
        race_w = 8'b0011_1001;
        for (int i = 0; i < N; i++) race_r[i] = 2;
        run_eval(8'hC3, 2, 1'b1, 1'b1);
        chk("stale_response", 32'(response), 32'h39);

        for (int e = 0; e < 12; e++) begin
            for (int i = 0; i < N; i++) race_r[i] = $urandom_range(1, 12);
            race_w = 8'($urandom);
            never_from = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : N;
            run_eval(8'($urandom), $urandom_range(0, 6), 1'($urandom), ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_sequencer.md
# puf_sequencer

Synchronous controller that runs one complete serial PUF evaluation per host request. It latches an 8-bit challenge, loads the scrambler, and then for each response bit clears the counters and arbiter, enables the ring-oscillator banks, waits for the race result, and shifts it in. It sits between the host interface and the serial PUF datapath (scrambler, RO banks, post-mux counters, race arbiter). It replaces the bit-sequencing currently spread across the buffer logic with one explicit FSM that has a valid/ready handshake and a timeout.

## Interface
Parameters:
- RESP_BITS, 8: response bits per evaluation (1..16).
- SETTLE_CYCLES, 4: cycles clears are held with ROs disabled before each race (≥1).
- TIMEOUT_CYCLES, 1048576: maximum RUN cycles per bit before abort (≥4).
- SYNC_STAGES, 2: flops in each input synchronizer (≥2).

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; returns the FSM to IDLE.
- req_valid  in  1  host presents a challenge.
- req_ready  out  1  high only in IDLE.
- challenge  in  8  challenge word, sampled on req_valid && req_ready.
- resp_valid  out  1  response available.
- resp_ready  in  1  host accepts the response.
- response  out  RESP_BITS  collected bits; bit i is the i-th race.
- resp_error  out  1  set when the evaluation was aborted by timeout.
- busy  out  1  high in every state except IDLE.
- scr_challenge  out  8  latched challenge, driven to the scrambler.
- scr_reset  out  1  1-cycle pulse that loads scr_challenge into the scrambler.
- scr_increment  out  1  1-cycle pulse that advances the scrambler.
- ro_enable  out  32  RO enables for both banks.
- cnt_reset  out  1  post-mux counter reset.
- arb_reset  out  1  race arbiter reset.
- arb_done  in  1  arbiter done; asynchronous, RO domain.
- arb_out  in  1  arbiter winner bit; asynchronous, valid while arb_done is high.

## Operation
- States and their behaviour:
  - IDLE: drives cnt_reset=1, arb_reset=1, ro_enable=0. On an accepted request, latches challenge into scr_challenge, clears response, resp_error and bit_idx, and goes to LOAD.
  - LOAD: asserts scr_reset for 1 cycle, then goes to CLEAR.
  - CLEAR: drives cnt_reset=1, arb_reset=1, ro_enable=0 for SETTLE_CYCLES cycles, then goes to RUN.
  - RUN: drives cnt_reset=0, arb_reset=0, ro_enable=all ones, and increments the timeout counter.
    - When synchronized arb_done is high, goes to CAPTURE.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, sets resp_error and goes to DONE.
  - CAPTURE: drives ro_enable=0 and writes synchronized arb_out into response[bit_idx].
    - If bit_idx==RESP_BITS-1, goes to DONE.
    - Otherwise increments bit_idx and goes to NEXT.
  - NEXT: asserts scr_increment for 1 cycle, then goes to CLEAR.
  - DONE: drives resp_valid=1, cnt_reset=1, arb_reset=1, ro_enable=0. On resp_valid && resp_ready, returns to IDLE.
- arb_done and arb_out each pass through SYNC_STAGES flops before they are used.
- CAPTURE samples arb_out one cycle after done is seen, so arb_out has had an extra settling cycle.
- On timeout, bits at and above bit_idx stay 0. response and resp_error hold their values until the next request is accepted.
- req_valid is ignored while busy. challenge changes while busy have no effect.
- A synchronized arb_done seen outside RUN is ignored, including a stale done during CLEAR.

## Timing
- All outputs are registered except req_ready and busy, which are state decodes.
- Values during and immediately after reset:
  - state=IDLE, req_ready=1, busy=0.
  - resp_valid=0, response=0, resp_error=0.
  - ro_enable=0, cnt_reset=1, arb_reset=1.
  - scr_reset=0, scr_increment=0, scr_challenge=0.
- Request accepted in cycle T: scr_reset is high in T+1. The first CLEAR cycle is T+2. RUN starts at T+2+SETTLE_CYCLES.
- Cycles per bit = SETTLE_CYCLES + R + SYNC_STAGES + 2 (CAPTURE, NEXT), where R is the race time in cycles. The last bit has no NEXT; DONE follows CAPTURE directly.
- resp_valid can fall in the same cycle as resp_ready. A new request is accepted no earlier than the following cycle.
- Reset asserted mid-evaluation immediately forces the reset values above. The partial response is discarded and the synchronizers are cleared.

## Structure
- Package puf_seq_pkg holds:
  - the state enum typedef (IDLE, LOAD, CLEAR, RUN, CAPTURE, NEXT, DONE);
  - default constants for RESP_BITS, SETTLE_CYCLES, TIMEOUT_CYCLES and SYNC_STAGES;
  - the constant RO_ALL_ON = 32'hFFFF_FFFF.
- One sub-module, bit_sync (parameter STAGES, asynchronous reset to 0), is instantiated twice: once for arb_done, once for arb_out.
- The timeout counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Reset, then release with req_valid=0 -> req_ready=1, busy=0, cnt_reset=1, arb_reset=1, ro_enable=0, response=0, held indefinitely.
- Challenge 8'hA5; arbiter model returns winners 1,0,1,1,0,0,1,0 (done 50 cycles after RUN starts) -> exactly one scr_reset and 7 scr_increment pulses, response=8'b0100_1101, resp_error=0.
- Arbiter model never asserts done, TIMEOUT_CYCLES=64 -> resp_error=1, response=0, DONE reached 64 cycles after RUN starts.
- Same as the second case with resp_ready held low 20 cycles -> resp_valid and response stable throughout. After ready, one-cycle handshake, then req_ready=1 the next cycle.
- Reset pulsed during bit 3 RUN -> all outputs take their reset values. A new 8'h3C request completes normally with bit_idx restarting at 0.
- Stale arb_done held high entering CLEAR, plus req_valid toggling while busy -> no capture until RUN and no second request accepted.
